// File: rtl/synth_pkg.sv
// synth_pkg: shared note/velocity types and constants for the synth datapath
package synth_pkg;
  localparam int NUM_NOTES = 128;
  localparam int NOTE_W = 7;
  localparam int VEL_W = 3;
  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [VEL_W-1:0] vel_t;
endpackage

// File: rtl/lowest_free_enc.sv
// lowest_free_enc: index of the lowest set bit of free plus an any-set flag
module lowest_free_enc #(
  parameter int W = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  free,
  output logic [IW-1:0] idx,
  output logic          any_free
);
  assign any_free = |free;
  // scan from the top so the lowest free slot wins
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) idx = free[i] ? IW'(i) : idx;
  end
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: maps held notes onto voice slots with a one-note-per-cycle scan
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_NOTES-1:0]         note_in,
  input  vel_t [NUM_NOTES-1:0]         velocity_in,
  output logic [NUM_VOICES-1:0]        voice_active,
  output note_t [NUM_VOICES-1:0]       voice_note,
  output vel_t [NUM_VOICES-1:0]        voice_velocity,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic [NUM_VOICES-1:0]        voice_stop,
  output logic                         overflow,
  output logic                         sweep_done
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  note_t k;
  logic [NUM_VOICES-1:0] match;
  logic [IW-1:0] f;
  logic any_free;
  logic held;
  assign held = note_in[k];
  lowest_free_enc #(.W(NUM_VOICES)) u_enc (
    .free(~voice_active),
    .idx(f),
    .any_free(any_free)
  );
  // slot that currently owns the scanned note, at most one by construction
  always_comb begin
    match = '0;
    for (int v = 0; v < NUM_VOICES; v++) match[v] = voice_active[v] && voice_note[v] == k;
  end
  // scan counter and slot state; pulses live for exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      voice_active <= '0;
      voice_note <= '0;
      voice_velocity <= '0;
      voice_start <= '0;
      voice_stop <= '0;
      overflow <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      k <= k + 7'd1;
      voice_start <= '0;
      voice_stop <= '0;
      overflow <= 1'b0;
      sweep_done <= &k;
      if (held && |match) begin
        for (int v = 0; v < NUM_VOICES; v++)
          if (match[v]) voice_velocity[v] <= velocity_in[k];
      end else if (held && any_free) begin
        voice_active[f] <= 1'b1;
        voice_note[f] <= k;
        voice_velocity[f] <= velocity_in[k];
        voice_start[f] <= 1'b1;
      end else if (held) begin
        overflow <= 1'b1;
      end else begin
        for (int v = 0; v < NUM_VOICES; v++)
          if (match[v]) begin
            voice_active[v] <= 1'b0;
            voice_stop[v] <= 1'b1;
          end
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: randomized and directed checks against a slot-pool model
module tb_voice_allocator;
  import synth_pkg::*;
  localparam int NV = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] note_in = '0;
  vel_t [127:0] velocity_in = '0;
  logic [NV-1:0] voice_active, voice_start, voice_stop;
  note_t [NV-1:0] voice_note;
  vel_t [NV-1:0] voice_velocity;
  logic overflow, sweep_done;
  int total = 0;
  int bad = 0;
  logic [NV-1:0] m_act, m_start, m_stop;
  note_t [NV-1:0] m_note;
  vel_t [NV-1:0] m_vel;
  logic m_ovf, m_sd;
  int sp;
  int cyc = 0;
  int last_sd = -1;
  bit started [NV];
  int n_start, n_stop, n_ovf;

  voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk(clk), .rst(rst), .note_in(note_in), .velocity_in(velocity_in),
    .voice_active(voice_active), .voice_note(voice_note), .voice_velocity(voice_velocity),
    .voice_start(voice_start), .voice_stop(voice_stop), .overflow(overflow), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  // one clock: advance the pool model, then check every output 1 time unit after the edge
  task automatic step();
    int owner, fr;
    bit dup;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_act = '0; m_note = '0; m_vel = '0; m_start = '0; m_stop = '0; m_ovf = 0; m_sd = 0;
      sp = 0; last_sd = -1;
      for (int v = 0; v < NV; v++) started[v] = 0;
    end else begin
      m_start = '0; m_stop = '0; m_ovf = 0; m_sd = (sp == 127);
      owner = -1;
      for (int v = 0; v < NV; v++) if (m_act[v] && int'(m_note[v]) == sp) owner = v;
      if (note_in[sp]) begin
        if (owner >= 0) m_vel[owner] = velocity_in[sp];
        else begin
          fr = -1;
          for (int v = NV - 1; v >= 0; v--) if (!m_act[v]) fr = v;
          if (fr < 0) m_ovf = 1;
          else begin
            m_act[fr] = 1; m_note[fr] = note_t'(sp); m_vel[fr] = velocity_in[sp]; m_start[fr] = 1;
          end
        end
      end else if (owner >= 0) begin
        m_act[owner] = 0; m_stop[owner] = 1;
      end
      sp = (sp + 1) % 128;
    end
    #1;
    total += 7;
    if (voice_active !== m_act) begin bad++; $display("FAIL active: got %b want %b", voice_active, m_act); end
    if (voice_note !== m_note) begin bad++; $display("FAIL note: got %h want %h", voice_note, m_note); end
    if (voice_velocity !== m_vel) begin bad++; $display("FAIL velocity: got %h want %h", voice_velocity, m_vel); end
    if (voice_start !== m_start) begin bad++; $display("FAIL start: got %b want %b", voice_start, m_start); end
    if (voice_stop !== m_stop) begin bad++; $display("FAIL stop: got %b want %b", voice_stop, m_stop); end
    if (overflow !== m_ovf) begin bad++; $display("FAIL overflow: got %b want %b", overflow, m_ovf); end
    if (sweep_done !== m_sd) begin bad++; $display("FAIL sweep_done: got %b want %b", sweep_done, m_sd); end
    dup = 0;
    for (int a = 0; a < NV; a++)
      for (int b = a + 1; b < NV; b++)
        if (voice_active[a] && voice_active[b] && voice_note[a] == voice_note[b]) dup = 1;
    total++;
    if (dup) begin bad++; $display("FAIL unique_notes: got duplicate in %h want none", voice_note); end
    if (sweep_done === 1'b1) begin
      if (last_sd >= 0) begin
        total++;
        if (cyc - last_sd != 128) begin bad++; $display("FAIL sweep_period: got %0d want 128", cyc - last_sd); end
      end
      last_sd = cyc;
    end
    for (int v = 0; v < NV; v++) begin
      if (voice_start[v] === 1'b1) begin
        total++;
        if (started[v]) begin bad++; $display("FAIL alternate_start: slot %0d got start want stop", v); end
        started[v] = 1;
        n_start++;
      end
      if (voice_stop[v] === 1'b1) begin
        total++;
        if (!started[v]) begin bad++; $display("FAIL alternate_stop: slot %0d got stop want start", v); end
        started[v] = 0;
        n_stop++;
      end
    end
    if (overflow === 1'b1) n_ovf++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; run(2);
    total++;
    if ({voice_active, voice_note, voice_velocity, voice_start, voice_stop, overflow, sweep_done} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero active=%b want 0", voice_active);
    end
    rst = 0;
  endtask

  task automatic test_allocate();
    note_in[60] = 1; velocity_in[60] = 3'd5;
    n_start = 0; run(129);
    total += 4;
    if (n_start != 1) begin bad++; $display("FAIL alloc_starts: got %0d want 1", n_start); end
    if (voice_note[0] !== 7'd60) begin bad++; $display("FAIL alloc_note: got %0d want 60", voice_note[0]); end
    if (voice_velocity[0] !== 3'd5) begin bad++; $display("FAIL alloc_vel: got %0d want 5", voice_velocity[0]); end
    if (voice_active !== 8'b00000001) begin bad++; $display("FAIL alloc_active: got %b want 00000001", voice_active); end
  endtask

  task automatic test_release();
    note_in[64] = 1; velocity_in[64] = 3'd3; run(129);
    note_in[60] = 0; n_stop = 0; run(129);
    total += 2;
    if (n_stop != 1) begin bad++; $display("FAIL release_stops: got %0d want 1", n_stop); end
    if (voice_active !== 8'b00000010) begin bad++; $display("FAIL release_active: got %b want 00000010", voice_active); end
    note_in[72] = 1; velocity_in[72] = 3'd7; run(129);
    total += 2;
    if (voice_note[0] !== 7'd72) begin bad++; $display("FAIL realloc_note: got %0d want 72", voice_note[0]); end
    if (voice_active !== 8'b00000011) begin bad++; $display("FAIL realloc_active: got %b want 00000011", voice_active); end
  endtask

  task automatic test_overflow();
    note_in = '0;
    for (int n = 10; n <= 17; n++) begin note_in[n] = 1; velocity_in[n] = vel_t'($urandom_range(0, 7)); end
    note_in[100] = 1; velocity_in[100] = 3'd6;
    do_reset();
    n_ovf = 0; run(383);
    total++;
    if (n_ovf != 3) begin bad++; $display("FAIL overflow_count: got %0d want 3", n_ovf); end
    note_in[12] = 0; n_ovf = 0; run(128);
    total += 3;
    if (voice_note[2] !== 7'd100) begin bad++; $display("FAIL overflow_takeover: got %0d want 100", voice_note[2]); end
    if (voice_active !== 8'hff) begin bad++; $display("FAIL overflow_active: got %b want 11111111", voice_active); end
    if (n_ovf != 0) begin bad++; $display("FAIL overflow_after_free: got %0d want 0", n_ovf); end
  endtask

  task automatic test_velocity();
    note_in = '0; note_in[60] = 1; velocity_in[60] = 3'd5;
    do_reset(); run(129);
    velocity_in[60] = 3'd2; n_start = 0; n_stop = 0; run(129);
    total += 2;
    if (voice_velocity[0] !== 3'd2) begin bad++; $display("FAIL vel_track: got %0d want 2", voice_velocity[0]); end
    if (n_start + n_stop != 0) begin bad++; $display("FAIL vel_pulses: got %0d want 0", n_start + n_stop); end
  endtask

  task automatic test_reset_mid();
    note_in = '0;
    note_in[90] = 1; note_in[20] = 1; note_in[55] = 1; note_in[5] = 1;
    do_reset(); run(178);
    rst = 1; step(); rst = 0;
    total++;
    if ({voice_active, voice_note, voice_velocity, voice_start, voice_stop, overflow, sweep_done} !== '0) begin
      bad++; $display("FAIL midreset_outputs: got active=%b stop=%b want 0", voice_active, voice_stop);
    end
    run(128);
    total += 2;
    if (voice_note[3:0] !== {7'd90, 7'd55, 7'd20, 7'd5}) begin bad++; $display("FAIL midreset_order: got %h want 5,20,55,90", voice_note[3:0]); end
    if (voice_active !== 8'b00001111) begin bad++; $display("FAIL midreset_active: got %b want 00001111", voice_active); end
  endtask

  task automatic test_random();
    int pool [12];
    int nn;
    for (int i = 0; i < 12; i++) pool[i] = $urandom_range(0, 127);
    note_in = '0; do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      for (int j = 0; j < 3; j++) begin
        nn = pool[$urandom_range(0, 11)];
        note_in[nn] = $urandom_range(0, 1) == 1;
        velocity_in[nn] = vel_t'($urandom_range(0, 7));
      end
      run($urandom_range(50, 300));
    end
    note_in = '0; run(130);
    total++;
    if (voice_active !== '0) begin bad++; $display("FAIL random_drain: got %b want 0", voice_active); end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_release();
    test_overflow();
    test_velocity();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
